// File: rtl/iter_sequencer_pkg.sv
// Shared constants for the iteration sequencer and the control unit.
// Holds the FSM state encoding and the T0..T3 phase codes.
package iter_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] T0 = 2'b00;
    localparam logic [1:0] T1 = 2'b01;
    localparam logic [1:0] T2 = 2'b10;
    localparam logic [1:0] T3 = 2'b11;

endpackage

// File: rtl/iter_sequencer_phase_counter.sv
// Two-bit T0..T3 phase counter with enable and synchronous clear.
// Ports: clk, rst_n, en, clr in; phase (registered), wrap (T3 && en) out.
module phase_counter
    import iter_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [1:0] phase,
    output logic       wrap
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= T0;
        end else if (clr) begin
            phase <= T0;
        end else if (en) begin
            phase <= phase + 2'd1;
        end
    end

    // Last phase of an iteration that is actually being advanced.
    assign wrap = en && (phase == T3);

endmodule

// File: rtl/iter_sequencer.sv
// Timing generator: runs N four-phase T loops, then E, then a done pulse.
// Ports: clk, rst_n, start, n_iter, hold, abort in; T, E, busy, done, iter_cnt out.
module iter_sequencer
    import iter_sequencer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_iter,
    input  logic             hold,
    input  logic             abort,
    output logic [1:0]       T,
    output logic             E,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_cnt
);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             ph_en;
    logic             ph_clr;
    logic             wrap;

    // The phase only moves in RUN; any other state (or an abort)
    // parks it at T0 so the next run and FINISH both see T0.
    assign ph_en  = (state == ST_RUN) && !hold;
    assign ph_clr = (state != ST_RUN) || abort;

    phase_counter u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ph_en),
        .clr   (ph_clr),
        .phase (T),
        .wrap  (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            E         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            iter_cnt  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        iter_cnt <= '0;
                        busy     <= 1'b1;
                        if (n_iter != '0) begin
                            remaining <= n_iter;
                            state     <= ST_RUN;
                        end else begin
                            remaining <= '0;
                            E         <= 1'b1;
                            state     <= ST_FINISH;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (wrap) begin
                        remaining <= remaining - CNT_W'(1);
                        iter_cnt  <= iter_cnt + CNT_W'(1);
                        // Last iteration: remaining reaches zero now.
                        if (remaining == CNT_W'(1)) begin
                            E     <= 1'b1;
                            state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    E    <= 1'b0;
                    busy <= 1'b0;
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
